// File: rtl/vernam_decipher.sv
// Vernam stream decipher: regenerates the key stream from a shared seed with an
// 8-bit Fibonacci LFSR, XORs it onto ciphertext and buffers plaintext in a FIFO.
module vernam_decipher #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [7:0]       seed_in,
  input  logic             cipher_valid,
  input  logic [7:0]       cipher_data,
  output logic             cipher_ready,
  output logic             plain_valid,
  output logic [7:0]       plain_data,
  input  logic             plain_ready,
  output logic             running,
  output logic [CNT_W-1:0] byte_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q;
  logic [7:0]       lfsr_q;
  logic [7:0]       lfsr_d;
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic [7:0]       last_pop_q;
  logic [CNT_W-1:0] byte_count_q;
  logic             full;
  logic             accept;
  logic             pop;

  assign full         = (count_q == FULL_CNT);
  assign running      = (state_q == RUN);
  assign cipher_ready = running && !full;
  assign plain_valid  = (count_q != '0);
  assign plain_data   = plain_valid ? mem_q[rd_ptr_q] : last_pop_q;
  assign byte_count   = byte_count_q;

  // A seed_load cycle wins over any transfer offered in the same cycle.
  assign accept = cipher_valid && cipher_ready && !seed_load;
  assign pop    = plain_valid && plain_ready && !seed_load;

  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lfsr_q       <= 8'h01;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_pop_q   <= 8'h00;
      byte_count_q <= '0;
    end else if (seed_load) begin
      // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
      state_q      <= RUN;
      lfsr_q       <= (seed_in == 8'h00) ? 8'h01 : seed_in;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      byte_count_q <= '0;
    end else begin
      count_q <= count_d;
      if (accept) begin
        lfsr_q       <= lfsr_d;
        wr_ptr_q     <= wr_ptr_q + 1'b1;
        byte_count_q <= byte_count_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        last_pop_q <= mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= cipher_data ^ lfsr_q;
    end
  end

endmodule

// File: tb/tb_vernam_decipher.sv
// Self-checking bench for vernam_decipher: directed scenarios with literal
// expectations plus randomized traffic compared against a queue-based model.
module tb_vernam_decipher;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             seedLoad = 1'b0;
  logic [7:0]       seedIn = 8'h00;
  logic             cipherValid = 1'b0;
  logic [7:0]       cipherData = 8'h00;
  logic             plainReady = 1'b0;
  logic             cipher_ready;
  logic             plain_valid;
  logic [7:0]       plain_data;
  logic             running;
  logic [CNT_W-1:0] byte_count;

  int checks = 0;
  int passes = 0;

  bit               modelValid = 1'b0;
  bit               modelRunning = 1'b0;
  logic [7:0]       modelKey = 8'h01;
  logic [7:0]       modelLastPop = 8'h00;
  logic [CNT_W-1:0] modelCount = '0;
  logic [7:0]       modelQ[$];
  logic [7:0]       popLog[$];

  vernam_decipher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .seed_load    (seedLoad),
    .seed_in      (seedIn),
    .cipher_valid (cipherValid),
    .cipher_data  (cipherData),
    .cipher_ready (cipher_ready),
    .plain_valid  (plain_valid),
    .plain_data   (plain_data),
    .plain_ready  (plainReady),
    .running      (running),
    .byte_count   (byte_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] nextKey(input logic [7:0] k);
    return {k[6:0], ^(k & 8'hB8)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
  endtask

  // Reference model: plaintext queue plus key register, stepped on each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      modelValid   = 1'b1;
      modelRunning = 1'b0;
      modelKey     = 8'h01;
      modelLastPop = 8'h00;
      modelCount   = '0;
      modelQ.delete();
    end else if (seedLoad) begin
      modelRunning = 1'b1;
      modelKey     = (seedIn == 8'h00) ? 8'h01 : seedIn;
      modelCount   = '0;
      modelQ.delete();
    end else if (modelRunning) begin
      bit acc;
      acc = cipherValid && (modelQ.size() < DEPTH);
      if (plainReady && modelQ.size() > 0) modelLastPop = modelQ.pop_front();
      if (acc) begin
        modelQ.push_back(cipherData ^ modelKey);
        modelKey   = nextKey(modelKey);
        modelCount = modelCount + 1'b1;
      end
    end
  end

  // Compare process: every falling edge once the model has seen a reset.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("cipher_ready", 32'(cipher_ready), 32'(modelRunning && modelQ.size() < DEPTH));
      checkOutput("running", 32'(running), 32'(modelRunning));
      checkOutput("plain_valid", 32'(plain_valid), 32'(modelQ.size() > 0));
      checkOutput("plain_data", 32'(plain_data), 32'((modelQ.size() > 0) ? modelQ[0] : modelLastPop));
      checkOutput("byte_count", 32'(byte_count), 32'(modelCount));
      if (plain_valid && plainReady && !seedLoad && !reset) popLog.push_back(plain_data);
    end
  end

  task automatic applyStimulus(input bit sl, input logic [7:0] sd, input bit cv,
                               input logic [7:0] cd, input bit pr, output bit accepted);
    seedLoad    = sl;
    seedIn      = sd;
    cipherValid = cv;
    cipherData  = cd;
    plainReady  = pr;
    @(negedge clk);
    accepted = cv && cipher_ready && !sl;
    @(posedge clk);
    #2;
  endtask

  task automatic idleCycles(input int n, input bit pr);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, pr, acc);
  endtask

  task automatic seedPulse(input logic [7:0] sd, input bit pr);
    bit acc;
    applyStimulus(1'b1, sd, 1'b0, 8'h00, pr, acc);
  endtask

  task automatic resetPulse();
    bit acc;
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, acc);
    reset = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] cd, input bit pr, input int budget, output bit ok);
    bit acc;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, cd, pr, acc);
      ok = acc;
    end
  endtask

  // Five-byte stream seeded with the given value; the literal plaintext pins the model.
  task automatic runBasicStream(input logic [7:0] sd, input string tag);
    logic [7:0] cin [5];
    logic [7:0] pexp [5];
    bit ok;
    cin  = '{8'h49, 8'h6A, 8'h48, 8'h7F, 8'h00};
    pexp = '{8'h48, 8'h68, 8'h4C, 8'h77, 8'h11};
    resetPulse();
    seedPulse(sd, 1'b1);
    popLog.delete();
    for (int i = 0; i < 5; i++) begin
      sendByte(cin[i], 1'b1, 1, ok);
      checkOutput({tag, "_accept"}, 32'(ok), 32'd1);
      checkOutput({tag, "_latency_valid"}, 32'(plain_valid), 32'd1);
      checkOutput({tag, "_latency_data"}, 32'(plain_data), 32'(pexp[i]));
    end
    idleCycles(2, 1'b1);
    checkOutput({tag, "_pop_count"}, 32'(popLog.size()), 32'd5);
    for (int i = 0; i < 5 && i < popLog.size(); i++)
      checkOutput({tag, "_plain"}, 32'(popLog[i]), 32'(pexp[i]));
    checkOutput({tag, "_byte_count"}, 32'(byte_count), 32'd5);
  endtask

  initial begin
    bit ok;
    bit acc;
    int accepted;
    logic [7:0] fillExp [6];
    fillExp = '{8'hA1, 8'hA3, 8'hA6, 8'hAB, 8'hB5, 8'h86};

    idleCycles(2, 1'b0);
    reset = 1'b0;

    // Unseeded block must refuse everything.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, acc);
      checkOutput("idle_ready", 32'(cipher_ready), 32'd0);
      checkOutput("idle_running", 32'(running), 32'd0);
      checkOutput("idle_plain_valid", 32'(plain_valid), 32'd0);
    end

    runBasicStream(8'h01, "seed01");
    runBasicStream(8'h00, "seed00");

    // Backpressure: only DEPTH bytes fit while the sink stalls.
    resetPulse();
    seedPulse(8'h01, 1'b0);
    popLog.delete();
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      sendByte(8'hA0 + 8'(i), 1'b0, 3, ok);
      if (ok) accepted++;
    end
    checkOutput("full_accepted", 32'(accepted), 32'd4);
    checkOutput("full_ready_low", 32'(cipher_ready), 32'd0);
    sendByte(8'hA4, 1'b1, 20, ok);
    checkOutput("resume_accept_4", 32'(ok), 32'd1);
    sendByte(8'hA5, 1'b1, 20, ok);
    checkOutput("resume_accept_5", 32'(ok), 32'd1);
    idleCycles(8, 1'b1);
    checkOutput("fill_pop_count", 32'(popLog.size()), 32'd6);
    for (int i = 0; i < 6 && i < popLog.size(); i++)
      checkOutput("fill_plain", 32'(popLog[i]), 32'(fillExp[i]));

    // Re-seed with bytes buffered and a byte offered in the same cycle.
    resetPulse();
    seedPulse(8'h01, 1'b0);
    sendByte(8'h10, 1'b0, 2, ok);
    sendByte(8'h20, 1'b0, 2, ok);
    applyStimulus(1'b1, 8'h01, 1'b1, 8'h33, 1'b1, acc);
    checkOutput("reseed_plain_valid", 32'(plain_valid), 32'd0);
    checkOutput("reseed_byte_count", 32'(byte_count), 32'd0);
    sendByte(8'h55, 1'b0, 2, ok);
    checkOutput("reseed_first_key", 32'(plain_data), 32'h54);

    // Reset mid-stream.
    sendByte(8'h66, 1'b0, 2, ok);
    resetPulse();
    checkOutput("rst_ready", 32'(cipher_ready), 32'd0);
    checkOutput("rst_valid", 32'(plain_valid), 32'd0);
    checkOutput("rst_data", 32'(plain_data), 32'h00);
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_byte_count", 32'(byte_count), 32'd0);

    // Random traffic; long seed-free stretch forces byte_count to wrap.
    seedPulse(8'($urandom), 1'b0);
    for (int i = 0; i < 400; i++) begin
      applyStimulus((i > 250) && ($urandom_range(0, 39) == 0), 8'($urandom),
                    $urandom_range(0, 3) != 0, 8'($urandom),
                    $urandom_range(0, 2) != 0, acc);
    end
    idleCycles(6, 1'b1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
